// File: rtl/sha_256_arb.sv
// sha_256_arb
// Two-requester round-robin arbiter in front of one shared SHA-256 core.
// Each requester hands over a padded 512-bit block with a valid/ready
// handshake. The block is forwarded to the core, and the digest comes back
// on that requester's response port through a second valid/ready handshake.
// A core that never finishes is aborted after CORE_TIMEOUT RUN cycles. The
// abort returns an all-zero digest and sets a sticky timeout_err flag.
//
// Ports
//   clk                      : single clock, rising edge
//   rst                      : asynchronous reset, active low
//   req0_valid / req1_valid  : requester presents a block
//   req0_data  / req1_data   : 512-bit padded block, word 0 in the MSBs
//   req0_ready / req1_ready  : block is accepted when valid & ready
//   rsp0_valid / rsp1_valid  : digest available for that requester
//   rsp0_hash  / rsp1_hash   : 256-bit digest (zero after an abort)
//   rsp0_ready / rsp1_ready  : requester consumes the digest
//   core_data                : block driven to the core
//   core_start               : start strobe to the core, high for all of RUN
//   core_done  / core_sig    : done flag and digest from the core
//   busy                     : arbiter is not idle
//   grant_id                 : requester that currently owns the core
//   timeout_err              : sticky abort flag, cleared only by reset
module sha_256_arb #(
  parameter int unsigned CORE_TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [511:0] req0_data,
  input  logic [511:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [255:0] rsp0_hash,
  output logic [255:0] rsp1_hash,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [511:0] core_data,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] core_sig,
  output logic         busy,
  output logic         grant_id,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(CORE_TIMEOUT - 1);

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_last_grant;
  logic           r_grant;
  logic [15:0]    r_wait_cnt;
  logic [511:0]   r_core_data;
  logic [255:0]   r_hash0;
  logic [255:0]   r_hash1;
  logic           r_rsp0_valid;
  logic           r_rsp1_valid;
  logic           r_timeout;

  logic           w_sel;
  logic           w_req0_ready;
  logic           w_req1_ready;
  logic           w_accept;
  logic           w_done;
  logic           w_timeout;
  logic           w_release;
  logic           w_rsp_ready;

  // Next-state logic, arbitration and handshake strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_sel        = 1'b0;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_release    = 1'b0;
    w_rsp_ready  = r_grant ? rsp1_ready : rsp0_ready;

    // Round robin: under contention the requester not served last time
    // wins. A lone valid requester always wins.
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        // Ready is gated by rst so that it reads 0 for as long as reset is held.
        if (!core_done && rst) begin
          w_req0_ready = req0_valid && !w_sel;
          w_req1_ready = req1_valid &&  w_sel;
          w_accept     = w_req0_ready || w_req1_ready;
          if (w_accept) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A done flag in the last allowed cycle is still a success.
        if (core_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait for the core to return to idle before it can be reissued.
        if (!core_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_wait_cnt   <= '0;
      r_core_data  <= '0;
      r_hash0      <= '0;
      r_hash1      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_data  <= w_sel ? req1_data : req0_data;
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_wait_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end

      // Only the granted port's hash is updated. The other port keeps
      // whatever digest it last delivered.
      if (w_done || w_timeout) begin
        if (r_grant) begin
          r_hash1      <= w_done ? core_sig : '0;
          r_rsp1_valid <= 1'b1;
        end else begin
          r_hash0      <= w_done ? core_sig : '0;
          r_rsp0_valid <= 1'b1;
        end
      end

      if (w_timeout) begin
        r_timeout <= 1'b1;
      end

      if (w_release) begin
        if (r_grant) begin
          r_rsp1_valid <= 1'b0;
        end else begin
          r_rsp0_valid <= 1'b0;
        end
      end
    end
  end

  assign req0_ready  = w_req0_ready;
  assign req1_ready  = w_req1_ready;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_hash   = r_hash0;
  assign rsp1_hash   = r_hash1;
  assign core_data   = r_core_data;
  assign core_start  = (r_state == S_RUN);
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_sha_256_arb.sv
// tb_sha_256_arb
// Bench for sha_256_arb. A behavioural stand-in for the SHA-256 core answers
// from a table of known digests. Stimulus pushes the expected responses into
// a queue, and a monitor pops and compares them as responses appear.
module tb_sha_256_arb;

  localparam logic [511:0] ABC_BLOCK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLOCK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_HASH    =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_HASH  =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam int CORE_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [511:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [255:0] rsp0_hash, rsp1_hash;
  logic         rsp0_ready, rsp1_ready;
  logic [511:0] core_data;
  logic         core_start;
  logic         core_done;
  logic [255:0] core_sig;
  logic         busy, grant_id, timeout_err;
  logic         core_stall;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic         port;
    logic [255:0] hash;
  } exp_t;
  exp_t exp_q[$];

  sha_256_arb #(.CORE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_hash(rsp0_hash), .rsp1_hash(rsp1_hash),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .core_data(core_data), .core_start(core_start),
    .core_done(core_done), .core_sig(core_sig),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  function automatic logic [255:0] core_lookup(input logic [511:0] d);
    if (d == ABC_BLOCK)   return ABC_HASH;
    if (d == EMPTY_BLOCK) return EMPTY_HASH;
    return 256'hbad0;
  endfunction

  // Core stand-in: raises done CORE_LAT cycles into core_start and holds it
  // for two cycles after start drops, so that the DRAIN state gets exercised.
  initial begin
    int run_cnt = 0;
    int post_cnt = 0;
    core_done = 1'b0;
    core_sig  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        core_done = 1'b0; core_sig = '0; run_cnt = 0; post_cnt = 0;
      end else if (core_start && !core_stall) begin
        run_cnt++;
        if (run_cnt >= CORE_LAT) begin
          core_done = 1'b1;
          core_sig  = core_lookup(core_data);
        end
      end else begin
        run_cnt = 0;
        if (core_done) begin
          post_cnt++;
          if (post_cnt >= 2) begin
            core_done = 1'b0; core_sig = '0; post_cnt = 0;
          end
        end
      end
    end
  end

  // Monitor and scoreboard
  initial begin
    logic         pv0 = 1'b0, pv1 = 1'b0, pcs = 1'b0, outstanding = 1'b0;
    logic [255:0] ph0 = '0, ph1 = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pv0 = 1'b0; pv1 = 1'b0; pcs = 1'b0; outstanding = 1'b0; ph0 = '0; ph1 = '0;
      end else begin
        if (core_start && !pcs) begin
          chk("start_overlap", outstanding, 1'b0);
          outstanding = 1'b1;
        end
        if ((rsp0_valid && !pv0) || (rsp1_valid && !pv1)) begin
          outstanding = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual=rsp0:%0d rsp1:%0d required=none", rsp0_valid, rsp1_valid);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_port", rsp1_valid, e.port);
            chk("rsp_hash", rsp1_valid ? rsp1_hash : rsp0_hash, e.hash);
            chk("rsp_grant_id", grant_id, e.port);
          end
        end
        // A hash may change only on the cycle its valid rises.
        if (!(rsp0_valid && !pv0)) chk("rsp0_hold", rsp0_hash, ph0);
        if (!(rsp1_valid && !pv1)) chk("rsp1_hold", rsp1_hash, ph1);
        if (rsp0_valid || rsp1_valid) chk("rsp_exclusive", rsp0_valid && rsp1_valid, 1'b0);
        pv0 = rsp0_valid; pv1 = rsp1_valid; pcs = core_start;
        ph0 = rsp0_hash;  ph1 = rsp1_hash;
      end
    end
  end

  task automatic issue(input logic p, input logic [511:0] d);
    int  n  = 0;
    logic ok = 1'b0;
    @(negedge clk);
    if (p) begin req1_data = d; req1_valid = 1'b1; end
    else   begin req0_data = d; req0_valid = 1'b1; end
    forever begin
      #1;
      if (p ? req1_ready : req0_ready) begin ok = 1'b1; break; end
      if (n++ >= 400) break;
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      bound_fail(p ? "accept_req1" : "accept_req0");
    end
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !busy && !rsp0_valid && !rsp1_valid) return;
    end
    bound_fail("drain");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_core_data"},  core_data, '0);
    chk({tag, "_busy"},       busy, 1'b0);
    chk({tag, "_grant_id"},   grant_id, 1'b0);
    chk({tag, "_timeout"},    timeout_err, 1'b0);
    chk({tag, "_rsp_valids"}, {rsp1_valid, rsp0_valid}, 2'b00);
    chk({tag, "_rsp0_hash"},  rsp0_hash, '0);
    chk({tag, "_rsp1_hash"},  rsp1_hash, '0);
    chk({tag, "_readies"},    {req1_ready, req0_ready}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0;    req1_data = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    core_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single "abc" request on port 0
    exp_q.push_back('{port: 1'b0, hash: ABC_HASH});
    issue(1'b0, ABC_BLOCK);
    chk("single_core_start", core_start, 1'b1);
    chk("single_grant", grant_id, 1'b0);
    chk("single_core_data", core_data, ABC_BLOCK);
    wait_drain();
    chk("single_timeout_err", timeout_err, 1'b0);

    // Both requesters valid out of reset: expected order req0, req1, req0
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = ABC_BLOCK;
    req1_valid = 1'b1; req1_data = EMPTY_BLOCK;
    #1;
    chk("reset_readies_gated", {req1_ready, req0_ready}, 2'b00);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    #4;
    rst = 1'b1;
    exp_q.push_back('{port: 1'b0, hash: ABC_HASH});
    exp_q.push_back('{port: 1'b1, hash: EMPTY_HASH});
    exp_q.push_back('{port: 1'b0, hash: EMPTY_HASH});
    fork
      begin issue(1'b0, ABC_BLOCK); issue(1'b0, EMPTY_BLOCK); end
      begin issue(1'b1, EMPTY_BLOCK); end
    join
    wait_drain();

    // Backpressure on rsp1 with req0 waiting
    rsp1_ready = 1'b0;
    exp_q.push_back('{port: 1'b1, hash: EMPTY_HASH});
    exp_q.push_back('{port: 1'b0, hash: ABC_HASH});
    issue(1'b1, EMPTY_BLOCK);
    fork
      issue(1'b0, ABC_BLOCK);
    join_none
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!rsp1_valid && n < 100);
    if (!rsp1_valid) bound_fail("bp_rsp1_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      chk("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk("bp_rsp1_hash", rsp1_hash, EMPTY_HASH);
      chk("bp_no_accept", {req0_ready, core_start, busy}, 3'b001);
    end
    rsp1_ready = 1'b1;
    wait fork;
    wait_drain();

    // Core never finishes: abort after 8 RUN cycles
    core_stall = 1'b1;
    exp_q.push_back('{port: 1'b0, hash: '0});
    issue(1'b0, ABC_BLOCK);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (rsp0_valid) break;
      if (core_start) n++;
    end
    chk("to_run_cycles", n, 8);
    chk("to_timeout_err", timeout_err, 1'b1);
    @(negedge clk);
    #2;
    chk("to_drain_core_start", {busy, core_start}, 2'b10);
    core_stall = 1'b0;
    wait_drain();
    exp_q.push_back('{port: 1'b1, hash: ABC_HASH});
    issue(1'b1, ABC_BLOCK);
    wait_drain();
    chk("to_sticky", timeout_err, 1'b1);

    // Reset asserted mid-RUN: no response, then a clean restart
    issue(1'b1, EMPTY_BLOCK);
    @(negedge clk);
    #2;
    chk("midrun_core_start", core_start, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun");
    @(negedge clk);
    #3;
    rst = 1'b1;
    exp_q.push_back('{port: 1'b0, hash: ABC_HASH});
    issue(1'b0, ABC_BLOCK);
    chk("restart_grant", grant_id, 1'b0);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_256_arb.md
SHA_256_ARB -- requirements
Module: sha_256_arb

Interface
REQ-001 The block SHALL have parameter CORE_TIMEOUT, default 256, meaning the maximum number of WAIT cycles allowed for core_done before abort.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all flops on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, meaning the requester presents a 512-bit padded block.
REQ-005 The block SHALL have ports req0_data/req1_data, input, 512 each, meaning the message block with bit 0 first (MSB-first word order).
REQ-006 The block SHALL have ports req0_ready/req1_ready, output, 1 each, meaning the block is accepted this cycle when valid&ready.
REQ-007 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, meaning a digest is available for that requester.
REQ-008 The block SHALL have ports rsp0_hash/rsp1_hash, output, 256 each, meaning the digest.
REQ-009 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1 each, meaning the requester consumes the digest.
REQ-010 The block SHALL have port core_data, output, 512, meaning the block driven to the shared SHA-256 core's i_data.
REQ-011 The block SHALL have port core_start, output, 1, driven to the core's sha_start.
REQ-012 The block SHALL have ports core_done, input, 1, and core_sig, input, 256, taken from the core's hash_done and signature.
REQ-013 The block SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-014 The block SHALL have port grant_id, output, 1, meaning the requester currently owning the core.
REQ-015 The block SHALL have port timeout_err, output, 1, a sticky abort flag.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, RESP and DRAIN.
REQ-017 In IDLE with core_done low, reqN_ready SHALL equal 1 only for the requester selected by round-robin; with core_done high, both readies SHALL be 0.
REQ-018 Round-robin rules: one valid → that requester is granted; both valid → the requester not granted last time is granted; after reset, requester 0 has priority.
REQ-019 On accept (valid&ready in IDLE), the block SHALL latch data into core_data, latch the requester into grant_id, update last-grant and go to RUN on the next edge.
REQ-020 In RUN, core_start SHALL be 1, and a 16-bit wait counter (cleared on entry) SHALL increment each cycle.
REQ-021 RUN with core_done=1 → latch core_sig into the granted rspN_hash, set rspN_valid, and go to RESP; core_start SHALL drop the same edge.
REQ-022 RUN with counter = CORE_TIMEOUT-1 and core_done=0 → set timeout_err, set rspN_valid with hash 256'h0, and go to RESP.
REQ-023 In RESP, rspN_valid and rspN_hash SHALL hold stable until rspN_ready=1; on that edge, clear rspN_valid and go to DRAIN.
REQ-024 In DRAIN, core_start SHALL be 0; leave to IDLE once core_done=0. This guarantees the core has returned to its idle state before reissue.
REQ-025 core_data SHALL stay constant from accept until leaving RUN.
REQ-026 Minimum latency SHALL be: accept edge T, core_start high at T+1, rspN_valid visible the cycle after core_done is sampled.
REQ-027 A requester holding valid while not granted SHALL NOT be dropped; its data is sampled only at its own accept.
REQ-028 The non-granted rsp port SHALL keep its previous hash value and have valid 0.
REQ-029 timeout_err SHALL clear only on reset.

Reset
REQ-030 While rst=0, the block SHALL force: state IDLE, core_start 0, core_data 0, all readies/valids 0, rsp hashes 0, grant_id 0, last-grant as requester 1 (so requester 0 wins first), counter 0, timeout_err 0, busy 0.
REQ-031 Reset assertion mid-RUN/RESP SHALL abort immediately with no response emitted; after release, normal arbitration restarts from IDLE.

Verification
REQ-032 The bench SHALL cover a single request: req0 with padded "abc" (61626380_0…0_00000018) → rsp0_hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, grant_id 0.
REQ-033 The bench SHALL cover simultaneous requests: req0 and req1 both valid from reset → order req0, req1, req0; each hash correct, and no overlap of core_start.
REQ-034 The bench SHALL cover backpressure: rsp1_ready held 0 for 20 cycles → rsp1_valid and hash stable for all 20 cycles, and no new accept until release.
REQ-035 The bench SHALL cover timeout: core_done tied 0 with CORE_TIMEOUT=8 → rsp valid with 0 hash after 8 RUN cycles, timeout_err 1, core_start 0 in DRAIN.
REQ-036 The bench SHALL cover reset mid-RUN: rst=0 for 1 cycle → all outputs reset values asynchronously, and the next request completes correctly.
